// File: rtl/seq_divider_pkg.sv
// Shared muldiv definitions: divider state encoding, op_div field positions and default width.
package seq_divider_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam int unsigned OPDIV_REM = 1;
    localparam int unsigned OPDIV_UNS = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the divisor, select.
module seq_divider_div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] dvd_i,
    input  logic [Width-1:0] dsr_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] dvd_o
);

    logic [Width:0] rem_sh;
    logic [Width:0] trial;

    assign rem_sh = {rem_i, dvd_i[Width-1]};
    assign trial  = rem_sh - {1'b0, dsr_i};

    // A negative trial keeps the shifted remainder, which is then below the divisor and fits Width.
    assign rem_o = trial[Width] ? rem_sh[Width-1:0] : trial[Width-1:0];
    assign dvd_o = {dvd_i[Width-2:0], ~trial[Width]};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider; responder on the div_start/div_rdy handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            div_start,
    input  logic [1:0]      op_div,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            div_rdy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic [XLEN-1:0] div_result
);

    localparam int unsigned    CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    div_state_e      state_q, state_d;
    logic            op_rem_q, op_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] orig_a_q, orig_a_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rmd_q, rmd_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_rem, step_dvd;

    assign a_neg = ~op_div[OPDIV_UNS] & A[XLEN-1];
    assign b_neg = ~op_div[OPDIV_UNS] & B[XLEN-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    seq_divider_div_step #(
        .Width(XLEN)
    ) u_step (
        .rem_i(rem_q),
        .dvd_i(dvd_q),
        .dsr_i(dsr_q),
        .rem_o(step_rem),
        .dvd_o(step_dvd)
    );

    always_comb begin
        state_d   = state_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        orig_a_d  = orig_a_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    op_rem_d  = op_div[OPDIV_REM];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (B == '0);
                    orig_a_d  = A;
                    dvd_d     = a_mag;
                    dsr_d     = b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (!div_start) begin
                    state_d = StIdle;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (!div_start) begin
                    state_d = StIdle;
                end else begin
                    // Signed overflow falls out naturally: -(0x80000000) wraps to itself.
                    if (div0_q) begin
                        quo_d = '1;
                        rmd_d = orig_a_q;
                    end else begin
                        quo_d = neg_quo_q ? -dvd_q : dvd_q;
                        rmd_d = neg_rem_q ? -rem_q : rem_q;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!div_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            orig_a_q  <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_rem_q  <= op_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            orig_a_q  <= orig_a_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
        end
    end

    assign div_rdy    = (state_q == StDone);
    assign quotient   = quo_q;
    assign remainder  = rmd_q;
    assign div_result = op_rem_q ? rmd_q : quo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results, one task per scenario.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [1:0]  op_div;
    logic [31:0] A;
    logic [31:0] B;
    logic        div_rdy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] div_result;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;
    logic [31:0] last_q;
    logic [31:0] last_r;

    seq_divider u_dut (
        .clk(clk),
        .reset(reset),
        .div_start(div_start),
        .op_div(op_div),
        .A(A),
        .B(B),
        .div_rdy(div_rdy),
        .quotient(quotient),
        .remainder(remainder),
        .div_result(div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M-extension divide semantics.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Pushes the expectation, starts an operation and waits (bounded) for div_rdy.
    // lat is the index of the first edge at which a controller would sample div_rdy=1, or 0.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] eq, input logic [31:0] er, output int lat);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.res = op[1] ? er : eq;
        sb.push_back(e);
        @(negedge clk);
        div_start = 1'b1;
        A         = a;
        B         = b;
        op_div    = op;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                A      = $urandom;
                B      = $urandom;
                op_div = 2'($urandom_range(0, 3));
            end
            if (div_rdy) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        div_start = 1'b0;
        op_div    = 2'b00;
        A         = 32'h0;
        B         = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (div_rdy !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0
            || div_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b q=%h r=%h res=%h, required all zero",
                     div_rdy, quotient, remainder, div_result);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        last_q = 32'h0;
        last_r = 32'h0;
    endtask

    task automatic test_vectors;
        logic [31:0] va[7];
        logic [31:0] vb[7];
        logic [1:0]  vop[7];
        logic [31:0] vq[7];
        logic [31:0] vr[7];
        int          lat;
        exp_t        e;
        va  = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000,
                32'h8000_0000, 32'd100};
        vb  = '{32'd7, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vop = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        vq  = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                32'h8000_0000, 32'hFFFF_FFF2};
        vr  = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0, 32'h0, 32'd2};
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vop[i], vq[i], vr[i], lat);
            e = sb.pop_front();
            tests_run++;
            if (lat != 34) begin
                tests_failed++;
                $display("FAIL vec%0d_latency: rdy seen at edge %0d, required 34", i, lat);
            end
            tests_run++;
            if (quotient !== e.q || remainder !== e.r || div_result !== e.res) begin
                tests_failed++;
                $display("FAIL vec%0d_result: q=%h r=%h res=%h, required q=%h r=%h res=%h",
                         i, quotient, remainder, div_result, e.q, e.r, e.res);
            end
            last_q    = e.q;
            last_r    = e.r;
            div_start = 1'b0;
            @(posedge clk);
            #1;
            tests_run++;
            if (div_rdy !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_release: rdy=%b, required 0", i, div_rdy);
            end
        end
    endtask

    task automatic test_hold;
        int   lat;
        exp_t e;
        do_op(32'd1003, 32'd10, 2'b01, 32'd100, 32'd3, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat != 34 || quotient !== e.q || remainder !== e.r) begin
            tests_failed++;
            $display("FAIL hold_result: lat=%0d q=%h r=%h, required lat=34 q=%h r=%h",
                     lat, quotient, remainder, e.q, e.r);
        end
        repeat (5) begin
            @(negedge clk);
            tests_run++;
            if (div_rdy !== 1'b1 || quotient !== e.q || div_result !== e.q) begin
                tests_failed++;
                $display("FAIL hold_stable: rdy=%b q=%h res=%h, required rdy=1 q=%h",
                         div_rdy, quotient, div_result, e.q);
            end
        end
        last_q    = e.q;
        last_r    = e.r;
        div_start = 1'b0;
        #1;
        tests_run++;
        if (div_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_before_edge: rdy=%b, required 1", div_rdy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (div_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_fall: rdy=%b, required 0", div_rdy);
        end
    endtask

    task automatic test_abort;
        logic seen;
        @(negedge clk);
        div_start = 1'b1;
        A         = 32'd5000;
        B         = 32'd7;
        op_div    = 2'b01;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        seen      = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_rdy) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_rdy: rdy seen=%b, required 0", seen);
        end
        tests_run++;
        if (quotient !== last_q || remainder !== last_r) begin
            tests_failed++;
            $display("FAIL abort_keep: q=%h r=%h, required q=%h r=%h",
                     quotient, remainder, last_q, last_r);
        end
    endtask

    task automatic test_reset_mid;
        int   lat;
        exp_t e;
        @(negedge clk);
        div_start = 1'b1;
        A         = 32'h1234_5678;
        B         = 32'd3;
        op_div    = 2'b01;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (div_rdy !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0
            || div_result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: rdy=%b q=%h r=%h res=%h, required all zero",
                     div_rdy, quotient, remainder, div_result);
        end
        div_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_op(32'hFFFF_FFFF, 32'h10, 2'b01, 32'h0FFF_FFFF, 32'hF, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat != 34 || quotient !== e.q || remainder !== e.r || div_result !== e.res) begin
            tests_failed++;
            $display("FAIL after_reset: lat=%0d q=%h r=%h res=%h, required lat=34 q=%h r=%h res=%h",
                     lat, quotient, remainder, div_result, e.q, e.r, e.res);
        end
        div_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_random;
        logic [31:0] a, b, q, r;
        logic [1:0]  op;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            if (i % 4 == 1) b = -b;
            op = 2'($urandom_range(0, 3));
            model(a, b, op, q, r);
            do_op(a, b, op, q, r, lat);
            e = sb.pop_front();
            tests_run++;
            if (lat != 34 || quotient !== e.q || remainder !== e.r || div_result !== e.res) begin
                tests_failed++;
                $display("FAIL rand%0d a=%h b=%h op=%b: lat=%0d q=%h r=%h res=%h, required lat=34 q=%h r=%h res=%h",
                         i, a, b, op, lat, quotient, remainder, div_result, e.q, e.r, e.res);
            end
            div_start = 1'b0;
            @(posedge clk);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_vectors();
        test_hold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
